// File: rtl/plazer_st_arb_pkg.sv
// Shared types and helpers for the packet-atomic Avalon-ST arbiter.
// Holds the FSM state type and the index-width helper.
package plazer_st_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Minimum 1 bit so a 1-entry index still has a legal width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/plazer_rr_arbiter.sv
// Combinational round-robin picker: first request after last_i wins.
// Produces one-hot grant, encoded index and an any-grant flag.
module plazer_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/plazer_st_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN byte streams
// into one registered channelized Avalon-ST stream.
module plazer_st_packet_arbiter
    import plazer_st_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int CHAN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    input  logic [NUM_IN-1:0]        chan_enable,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHAN_W-1:0]        out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic                     busy,
    output logic                     drop_pulse
);

    localparam int IW = clog2(NUM_IN);

    state_t            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CHAN_W-1:0] out_chan_q;
    logic              out_sop_q, out_eop_q;

    logic [NUM_IN-1:0] req, gnt, orph, ready;
    logic [IW-1:0]     win_idx, sel;
    logic              any_req, free, accept, drop;
    logic [DATA_W-1:0] data_arr [NUM_IN];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            data_arr[i] = in_data[i*DATA_W +: DATA_W];
        end
    end

    assign req  = in_valid & in_startofpacket & chan_enable;
    assign orph = in_valid & ~in_startofpacket;
    assign free = !out_valid_q || out_ready;

    plazer_rr_arbiter #(
        .N  (NUM_IN),
        .IW (IW)
    ) u_rr (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (any_req)
    );

    // Orphans are only dropped when no packet start is competing.
    always_comb begin
        ready  = '0;
        drop   = 1'b0;
        accept = 1'b0;
        sel    = grant_q;
        if (!reset) begin
            if (state_q == LOCK) begin
                ready[grant_q] = free;
                accept         = free && in_valid[grant_q];
            end else if (any_req) begin
                sel    = win_idx;
                ready  = free ? gnt : '0;
                accept = free;
            end else if (|orph) begin
                ready = orph & (~orph + NUM_IN'(1));
                drop  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (accept) begin
            if (state_q == IDLE) begin
                last_d = win_idx;
                if (!in_endofpacket[win_idx]) begin
                    state_d = LOCK;
                    grant_d = win_idx;
                end
            end else if (in_endofpacket[grant_q]) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NUM_IN - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_arr[sel];
                out_chan_q  <= CHAN_W'(sel);
                out_sop_q   <= in_startofpacket[sel];
                out_eop_q   <= in_endofpacket[sel];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready          = ready;
    assign drop_pulse        = drop;
    assign busy              = (state_q == LOCK);
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_channel       = out_chan_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;

endmodule
